// File: rtl/tetris_pkg.sv
// Shared Tetris constants: board size, colour codes, palette lookup and the board FSM encoding.
package tetris_pkg;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    localparam logic [2:0] C_EMPTY  = 3'd0;
    localparam logic [2:0] C_CYAN   = 3'd1;
    localparam logic [2:0] C_YELLOW = 3'd2;
    localparam logic [2:0] C_PURPLE = 3'd3;
    localparam logic [2:0] C_GREEN  = 3'd4;
    localparam logic [2:0] C_RED    = 3'd5;
    localparam logic [2:0] C_BLUE   = 3'd6;
    localparam logic [2:0] C_ORANGE = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    // An empty cell takes the caller's background colour.
    function automatic logic [11:0] palette(input logic [2:0] code, input logic [11:0] bg);
        case (code)
            C_EMPTY:  palette = bg;
            C_CYAN:   palette = 12'h0FF;
            C_YELLOW: palette = 12'hFF0;
            C_PURPLE: palette = 12'hA0F;
            C_GREEN:  palette = 12'h0F0;
            C_RED:    palette = 12'hF00;
            C_BLUE:   palette = 12'h00F;
            C_ORANGE: palette = 12'hF80;
            default:  palette = bg;
        endcase
    endfunction

endpackage

// File: rtl/tetris_board_ram.sv
// Board storage: one synchronous read port, one write port; a colliding read returns the old word.
module tetris_board_ram #(
    parameter int DEPTH = 200,
    parameter int WIDTH = 3,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/tetris_pixel_gen.sv
// Tetris playfield renderer: 2-tick pixel pipeline over the board RAM, vblank-gated cell writes
// and a post-reset / on-demand board clear sweep.
module tetris_pixel_gen #(
    parameter int          COLS      = tetris_pkg::COLS,
    parameter int          ROWS      = tetris_pkg::ROWS,
    parameter int          CELL_PX   = 16,
    parameter int          PF_X0     = 240,
    parameter int          PF_Y0     = 80,
    parameter logic [11:0] BG_RGB    = 12'h111,
    parameter logic [11:0] GRID_RGB  = 12'h333,
    parameter logic [11:0] FRAME_RGB = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_lvl,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [2:0]  wr_color,
    input  logic        clear_req,
    output logic        busy,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);
    import tetris_pkg::*;

    localparam int          DEPTH    = COLS * ROWS;
    localparam int          AW       = $clog2(DEPTH);
    localparam int          LOG_CELL = $clog2(CELL_PX);
    localparam logic [10:0] X_LO     = 11'(PF_X0);
    localparam logic [10:0] X_HI     = 11'(PF_X0 + COLS * CELL_PX);
    localparam logic [10:0] Y_LO     = 11'(PF_Y0);
    localparam logic [10:0] Y_HI     = 11'(PF_Y0 + ROWS * CELL_PX);
    localparam logic [9:0]  X0       = 10'(PF_X0);
    localparam logic [9:0]  Y0       = 10'(PF_Y0);
    localparam logic [9:0]  VBLANK_Y = 10'd480;

    logic          pix_prev_q, pix_prev_d, tick;
    logic [10:0]   x11, y11;
    logic [9:0]    dx, dy;
    logic          in_pf, on_frame, on_grid;
    logic [AW-1:0] pix_addr, wr_addr;
    logic          wr_in_range;

    logic          in_pf1_q, in_pf1_d, frame1_q, frame1_d, grid1_q, grid1_d;
    logic          vid1_q, vid1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs2_q, hs2_d, vs2_q, vs2_d;
    logic [2:0]    ram_rd_data, ram_wdata;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    assign tick = pix_lvl & ~pix_prev_q;
    assign x11  = {1'b0, x};
    assign y11  = {1'b0, y};
    assign dx   = x - X0;
    assign dy   = y - Y0;

    // The frame ring spans one pixel beyond the playfield on every side, corners included.
    always_comb begin
        in_pf    = (x11 >= X_LO) && (x11 < X_HI) && (y11 >= Y_LO) && (y11 < Y_HI);
        on_frame = ((x11 + 11'd1 == X_LO) || (x11 == X_HI)) && (y11 + 11'd1 >= Y_LO) && (y11 <= Y_HI);
        on_frame = on_frame ||
                   (((y11 + 11'd1 == Y_LO) || (y11 == Y_HI)) && (x11 + 11'd1 >= X_LO) && (x11 <= X_HI));
        on_grid  = in_pf && ((dx[LOG_CELL-1:0] == '0) || (dy[LOG_CELL-1:0] == '0));
        pix_addr = in_pf ? AW'(32'(dy >> LOG_CELL) * COLS + 32'(dx >> LOG_CELL)) : '0;
    end

    assign wr_in_range = (32'(wr_col) < COLS) && (32'(wr_row) < ROWS);
    assign wr_addr     = AW'(32'(wr_row) * COLS + 32'(wr_col));

    always_comb begin
        pix_prev_d = pix_lvl;
        in_pf1_d   = in_pf1_q;
        frame1_d   = frame1_q;
        grid1_d    = grid1_q;
        vid1_d     = vid1_q;
        hs1_d      = hs1_q;
        vs1_d      = vs1_q;
        rgb_d      = rgb_q;
        hs2_d      = hs2_q;
        vs2_d      = vs2_q;
        if (tick) begin
            in_pf1_d = in_pf;
            frame1_d = on_frame;
            grid1_d  = on_grid;
            vid1_d   = video_on;
            hs1_d    = hsync_in;
            vs1_d    = vsync_in;
            hs2_d    = hs1_q;
            vs2_d    = vs1_q;
            if (!vid1_q)       rgb_d = '0;
            else if (frame1_q) rgb_d = FRAME_RGB;
            else if (grid1_q)  rgb_d = GRID_RGB;
            else if (in_pf1_q) rgb_d = palette(ram_rd_data, BG_RGB);
            else               rgb_d = '0;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ready   = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = wr_addr;
        ram_wdata  = wr_color;
        case (state_q)
            ST_IDLE: begin
                wr_ready = (y >= VBLANK_Y);
                ram_we   = wr_valid && (y >= VBLANK_Y) && wr_in_range;
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = '0;
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_prev_q <= 1'b0;
            in_pf1_q   <= 1'b0;
            frame1_q   <= 1'b0;
            grid1_q    <= 1'b0;
            vid1_q     <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            rgb_q      <= '0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            pix_prev_q <= pix_prev_d;
            in_pf1_q   <= in_pf1_d;
            frame1_q   <= frame1_d;
            grid1_q    <= grid1_d;
            vid1_q     <= vid1_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            rgb_q      <= rgb_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    tetris_board_ram #(
        .DEPTH (DEPTH),
        .WIDTH (3),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (tick),
        .rd_addr (pix_addr),
        .rd_data (ram_rd_data),
        .wr_en   (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata)
    );

    assign busy      = (state_q == ST_CLEAR);
    assign rgb       = rgb_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;

endmodule

// File: tb/tb_tetris_pixel_gen.sv
// Directed bench for tetris_pixel_gen: reset sweep, vblank writes, geometry, pipeline alignment, clear.
module tb_tetris_pixel_gen;

    logic        clk = 1'b0;
    logic        reset, pix_lvl, video_on, hsync_in, vsync_in;
    logic [9:0]  x, y;
    logic        wr_valid, wr_ready, clear_req, busy;
    logic [3:0]  wr_col;
    logic [4:0]  wr_row;
    logic [2:0]  wr_color;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tetris_pixel_gen dut (
        .clk       (clk),
        .reset     (reset),
        .pix_lvl   (pix_lvl),
        .x         (x),
        .y         (y),
        .video_on  (video_on),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_color  (wr_color),
        .clear_req (clear_req),
        .busy      (busy),
        .rgb       (rgb),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out)
    );

    // One pixel tick: inputs and pix_lvl rise at a negedge, pix_lvl falls one clk later.
    task automatic step(input int px, input int py, input logic vo, input logic hs, input logic vs);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        video_on = vo;
        hsync_in = hs;
        vsync_in = vs;
        pix_lvl = 1'b1;
        @(negedge clk);
        pix_lvl = 1'b0;
    endtask

    task automatic write_cell(input int col, input int row, input int color, input string name);
        @(negedge clk);
        y = 10'd490;
        wr_valid = 1'b1;
        wr_col = 4'(col);
        wr_row = 5'(row);
        wr_color = 3'(color);
        #1;
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: wr_ready=%b required 1", name, wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        reset = 1'b1;
        repeat (3) step(300, 200, 1'b1, 1'b1, 1'b1);
        vectors++;
        if ({rgb, hsync_out, vsync_out} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: rgb=%h hs=%b vs=%b required 000 0 0", rgb, hsync_out, vsync_out);
        end
        video_on = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        reset = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        vectors++;
        if (cnt != 200) begin
            miscompares++;
            $display("FAIL reset_busy_len: busy clks=%0d required 200", cnt);
        end
        vectors++;
        if (rgb !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_flush_rgb: rgb=%h required 000", rgb);
        end
        step(245, 85, 1'b1, 1'b0, 1'b0);
        step(245, 85, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (rgb !== 12'h111) begin
            miscompares++;
            $display("FAIL reset_empty_cell: rgb=%h required 111", rgb);
        end
    endtask

    task automatic test_write_handshake;
        int bad;
        @(negedge clk);
        y = 10'd100;
        wr_valid = 1'b1;
        wr_col = 4'd2;
        wr_row = 5'd3;
        wr_color = 3'd3;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_ready !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL wr_ready_active: high on %0d clks required 0", bad);
        end
        y = 10'd480;
        #1;
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_ready_vblank: wr_ready=%b required 1", wr_ready);
        end
        @(negedge clk);
        wr_valid = 1'b0;
        step(277, 133, 1'b1, 1'b0, 1'b0);
        step(277, 133, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (rgb !== 12'hA0F) begin
            miscompares++;
            $display("FAIL written_cell: rgb=%h required A0F", rgb);
        end
    endtask

    task automatic test_geometry;
        int          gx [13] = '{256, 239, 100, 245, 400, 239, 300, 300, 401, 399, 240, 238, 300};
        int          gy [13] = '{ 90, 200, 100,  85, 400,  79,  79, 400, 200, 399, 200, 200, 401};
        logic        gv [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [11:0] ge [13] = '{12'h333, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'hFFF, 12'hFFF,
                                 12'hFFF, 12'h000, 12'h111, 12'h333, 12'h000, 12'h000};
        for (int i = 0; i < 13; i++) begin
            step(gx[i], gy[i], gv[i], 1'b0, 1'b0);
            step(gx[i], gy[i], gv[i], 1'b0, 1'b0);
            vectors++;
            if (rgb !== ge[i]) begin
                miscompares++;
                $display("FAIL geometry(%0d,%0d,vo=%b): rgb=%h required %h", gx[i], gy[i], gv[i], rgb, ge[i]);
            end
        end
    endtask

    task automatic test_pipeline;
        int          px [8] = '{245, 256, 239, 100, 277, 277, 0, 0};
        int          py [8] = '{ 85,  90, 200, 100, 133, 133, 0, 0};
        logic        pv [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        ph [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic        ps [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [11:0] pe [8] = '{12'h111, 12'h333, 12'hFFF, 12'h000, 12'hA0F, 12'h000, 12'h000, 12'h000};
        for (int i = 0; i < 8; i++) begin
            step(px[i], py[i], pv[i], ph[i], ps[i]);
            if (i >= 1) begin
                vectors++;
                if ({rgb, hsync_out, vsync_out} !== {pe[i-1], ph[i-1], ps[i-1]}) begin
                    miscompares++;
                    $display("FAIL pipeline[%0d]: rgb=%h hs=%b vs=%b required %h %b %b",
                             i - 1, rgb, hsync_out, vsync_out, pe[i-1], ph[i-1], ps[i-1]);
                end
            end
        end
    endtask

    task automatic test_clear;
        int          cx [4] = '{245, 390, 309, 277};
        int          cy [4] = '{ 85, 390, 245, 133};
        logic [11:0] ce [4] = '{12'hF00, 12'hF80, 12'h0FF, 12'hA0F};
        int cnt, bad;
        write_cell(0, 0, 5, "clr_fill0");
        write_cell(9, 19, 7, "clr_fill1");
        write_cell(4, 10, 1, "clr_fill2");
        for (int i = 0; i < 4; i++) begin
            step(cx[i], cy[i], 1'b1, 1'b0, 1'b0);
            step(cx[i], cy[i], 1'b1, 1'b0, 1'b0);
            vectors++;
            if (rgb !== ce[i]) begin
                miscompares++;
                $display("FAIL filled(%0d,%0d): rgb=%h required %h", cx[i], cy[i], rgb, ce[i]);
            end
        end
        @(negedge clk);
        y = 10'd490;
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        bad = 0;
        while (busy === 1'b1 && cnt < 400) begin
            cnt++;
            if (wr_ready !== 1'b0) bad++;
            clear_req = (cnt == 50);
            @(negedge clk);
        end
        clear_req = 1'b0;
        vectors++;
        if (cnt != 200) begin
            miscompares++;
            $display("FAIL clear_busy_len: busy clks=%0d required 200", cnt);
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL clear_wr_ready: high on %0d clks required 0", bad);
        end
        for (int i = 0; i < 4; i++) begin
            step(cx[i], cy[i], 1'b1, 1'b0, 1'b0);
            step(cx[i], cy[i], 1'b1, 1'b0, 1'b0);
            vectors++;
            if (rgb !== 12'h111) begin
                miscompares++;
                $display("FAIL cleared(%0d,%0d): rgb=%h required 111", cx[i], cy[i], rgb);
            end
        end
    endtask

    task automatic test_out_of_range;
        int ox [3] = '{245, 325, 357};
        int oy [3] = '{101, 101, 165};
        write_cell(10, 0, 5, "oor_col10");
        write_cell(15, 0, 4, "oor_col15");
        write_cell(0, 20, 2, "oor_row20");
        write_cell(3, 31, 7, "oor_row31");
        for (int i = 0; i < 3; i++) begin
            step(ox[i], oy[i], 1'b1, 1'b0, 1'b0);
            step(ox[i], oy[i], 1'b1, 1'b0, 1'b0);
            vectors++;
            if (rgb !== 12'h111) begin
                miscompares++;
                $display("FAIL oor_alias(%0d,%0d): rgb=%h required 111", ox[i], oy[i], rgb);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pix_lvl = 1'b0;
        x = '0;
        y = '0;
        video_on = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        wr_valid = 1'b0;
        wr_col = '0;
        wr_row = '0;
        wr_color = '0;
        clear_req = 1'b0;
        test_reset;
        test_write_handshake;
        test_geometry;
        test_pipeline;
        test_clear;
        test_out_of_range;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
